mem_access_stage: RTL and testbench

- Memory-access pipeline stage between execute and writeback in the 16-bit RISC core.
- Accepts one instruction per handshake from execute and drives the dataMem port set (write, read, rdAddr, wrAddr, data_in).
- Captures dataMem data_out for loads and presents a registered result to writeback.
- Sequences dataMem's one-cycle read latency with a two-state FSM and stalls execute while a load is outstanding.

---
 rtl/rsc_pkg.sv | 13 +
 rtl/mem_wb_reg.sv | 35 +++
 rtl/mem_access_stage.sv | 116 +++++++++++
 tb/tb_mem_access_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsc_pkg.sv
// rtl/rsc_pkg.sv - shared widths and state type for the memory-access stage
package rsc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int REG_W  = 3;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - writeback pipeline register; wb_valid is a one-cycle pulse per load
module mem_wb_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_reg_write,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write
);

  // Payload holds when idle; only the valid flag drops back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
    end else if (load) begin
      wb_valid     <= 1'b1;
      wb_rd        <= in_rd;
      wb_data      <= in_data;
      wb_reg_write <= in_reg_write;
    end else begin
      wb_valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage between execute and writeback
module mem_access_stage #(
  parameter int DATA_W = rsc_pkg::DATA_W,
  parameter int ADDR_W = rsc_pkg::ADDR_W,
  parameter int REG_W  = rsc_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_wrAddr,
  output logic [ADDR_W-1:0] mem_rdAddr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic              err
);

  import rsc_pkg::*;

  state_t             state;
  logic               accept;
  logic               do_store;
  logic               do_load;
  logic [REG_W-1:0]   ld_rd;
  logic               ld_reg_write;
  logic               wb_load;
  logic [REG_W-1:0]   wb_in_rd;
  logic [DATA_W-1:0]  wb_in_data;
  logic               wb_in_reg_write;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  // A store wins when both flags are set; the load half is dropped.
  assign do_store = accept & ex_is_store;
  assign do_load  = accept & ex_is_load & ~ex_is_store;

  // Strobes are gated by rst_n so the memory sees no access during reset.
  assign mem_write   = do_store & rst_n;
  assign mem_read    = do_load & rst_n;
  assign mem_wrAddr  = mem_write ? ex_addr : '0;
  assign mem_data_in = mem_write ? ex_store_data : '0;
  assign mem_rdAddr  = mem_read ? ex_addr : '0;

  always_comb begin
    wb_load         = 1'b0;
    wb_in_rd        = ex_rd;
    wb_in_data      = ex_alu_result;
    wb_in_reg_write = ex_reg_write;
    if (state == LOAD_WAIT) begin
      wb_load         = 1'b1;
      wb_in_rd        = ld_rd;
      wb_in_data      = mem_data_out;
      wb_in_reg_write = ld_reg_write;
    end else if (accept && !do_load) begin
      wb_load = 1'b1;
      if (ex_is_store) begin
        wb_in_reg_write = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ld_rd        <= '0;
      ld_reg_write <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (do_load) begin
            state        <= LOAD_WAIT;
            ld_rd        <= ex_rd;
            ld_reg_write <= ex_reg_write;
          end
        end
        LOAD_WAIT: begin
          state <= IDLE;
        end
      endcase
      if (accept && ex_is_load && ex_is_store) begin
        err <= 1'b1;
      end
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_wb_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (wb_load),
    .in_rd       (wb_in_rd),
    .in_data     (wb_in_data),
    .in_reg_write(wb_in_reg_write),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_reg_write(wb_reg_write)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_reg_write;
  logic [3:0]  ex_addr;
  logic [15:0] ex_store_data, ex_alu_result;
  logic [2:0]  ex_rd;
  logic        mem_write, mem_read;
  logic [3:0]  mem_wrAddr, mem_rdAddr;
  logic [15:0] mem_data_in, mem_data_out;
  logic        wb_valid, wb_reg_write, err;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] dmem [16];

  always #5 clk = ~clk;

  // Behavioural dataMem: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write) dmem[mem_wrAddr] <= mem_data_in;
    if (mem_read) mem_data_out <= dmem[mem_rdAddr];
  end

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_wrAddr(mem_wrAddr), .mem_rdAddr(mem_rdAddr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .err(err)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_addr = 0;
    ex_store_data = 0; ex_alu_result = 0; ex_rd = 0; ex_reg_write = 0;
  endtask

  task drive(input logic ld, input logic st, input logic [15:0] alu, input logic [15:0] sd,
             input logic [2:0] rd, input logic rw);
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_alu_result = alu;
    ex_addr = alu[3:0]; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
  endtask

  task test_reset;
    rst_n = 0;
    drive(0, 1, 16'h0003, 16'hBEEF, 3'd1, 1'b1);
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got=%0h exp=0", mem_write); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%0h exp=0", mem_read); end
    n_cmp++; if (mem_wrAddr !== 4'h0) begin n_fail++; $display("FAIL reset_wraddr got=%0h exp=0", mem_wrAddr); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got=%0h exp=1", ex_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    n_cmp++; if (wb_data !== 16'h0) begin n_fail++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
    n_cmp++; if (wb_rd !== 3'h0) begin n_fail++; $display("FAIL reset_wb_rd got=%0h exp=0", wb_rd); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_rw got=%0h exp=0", wb_reg_write); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", err); end
    idle;
    @(negedge clk);
    rst_n = 1;
  endtask

  task test_store;
    tick; drive(0, 1, 16'h0003, 16'hBEEF, 3'd1, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL store_mem_write got=%0h exp=1", mem_write); end
    n_cmp++; if (mem_wrAddr !== 4'h3) begin n_fail++; $display("FAIL store_wraddr got=%0h exp=3", mem_wrAddr); end
    n_cmp++; if (mem_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL store_data_in got=%0h exp=beef", mem_data_in); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL store_mem_read got=%0h exp=0", mem_read); end
    tick; idle;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL store_write_drop got=%0h exp=0", mem_write); end
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL store_wb_valid got=%0h exp=1", wb_valid); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL store_wb_rw got=%0h exp=0", wb_reg_write); end
    tick;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL store_wb_pulse got=%0h exp=0", wb_valid); end
  endtask

  task test_store_load;
    tick; drive(0, 1, 16'h0005, 16'h1234, 3'd0, 1'b0);
    tick; drive(1, 0, 16'h0005, 16'h0000, 3'd2, 1'b1);
    @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ld_accept_ready got=%0h exp=1", ex_ready); end
    n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ld_mem_read got=%0h exp=1", mem_read); end
    n_cmp++; if (mem_rdAddr !== 4'h5) begin n_fail++; $display("FAIL ld_rdaddr got=%0h exp=5", mem_rdAddr); end
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld_prev_store_wb got=%0h exp=1", wb_valid); end
    tick; drive(0, 0, 16'h00AA, 16'h0000, 3'd7, 1'b1);
    @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL ld_stall_ready got=%0h exp=0", ex_ready); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL ld_stall_read got=%0h exp=0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL ld_stall_write got=%0h exp=0", mem_write); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_stall_wb got=%0h exp=0", wb_valid); end
    tick; idle;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld_wb_valid got=%0h exp=1", wb_valid); end
    n_cmp++; if (wb_data !== 16'h1234) begin n_fail++; $display("FAIL ld_wb_data got=%0h exp=1234", wb_data); end
    n_cmp++; if (wb_rd !== 3'd2) begin n_fail++; $display("FAIL ld_wb_rd got=%0h exp=2", wb_rd); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL ld_wb_rw got=%0h exp=1", wb_reg_write); end
    tick;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_stall_not_taken got=%0h exp=0", wb_valid); end
  endtask

  task test_back_to_back;
    tick; drive(0, 0, 16'h0001, 16'h0000, 3'd3, 1'b1);
    tick; drive(0, 0, 16'h0002, 16'h0000, 3'd4, 1'b1);
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid0 got=%0h exp=1", wb_valid); end
    n_cmp++; if (wb_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_data0 got=%0h exp=1", wb_data); end
    n_cmp++; if (wb_rd !== 3'd3) begin n_fail++; $display("FAIL b2b_rd0 got=%0h exp=3", wb_rd); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_rw0 got=%0h exp=1", wb_reg_write); end
    tick; idle;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got=%0h exp=1", wb_valid); end
    n_cmp++; if (wb_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_data1 got=%0h exp=2", wb_data); end
    n_cmp++; if (wb_rd !== 3'd4) begin n_fail++; $display("FAIL b2b_rd1 got=%0h exp=4", wb_rd); end
    tick;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%0h exp=0", wb_valid); end
  endtask

  task test_addr_wrap;
    tick; drive(0, 1, 16'hFFFF, 16'h7E57, 3'd0, 1'b0);
    tick; drive(1, 0, 16'hFFFF, 16'h0000, 3'd5, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_rdAddr !== 4'hF) begin n_fail++; $display("FAIL wrap_rdaddr got=%0h exp=f", mem_rdAddr); end
    tick; idle;
    tick;
    @(negedge clk);
    n_cmp++; if (wb_data !== 16'h7E57) begin n_fail++; $display("FAIL wrap_ld15_data got=%0h exp=7e57", wb_data); end
    n_cmp++; if (wb_rd !== 3'd5) begin n_fail++; $display("FAIL wrap_ld15_rd got=%0h exp=5", wb_rd); end
    tick; drive(0, 1, 16'h0010, 16'hA5A5, 3'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (mem_wrAddr !== 4'h0) begin n_fail++; $display("FAIL wrap_wraddr got=%0h exp=0", mem_wrAddr); end
    tick; drive(1, 0, 16'h1230, 16'h0000, 3'd6, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_rdAddr !== 4'h0) begin n_fail++; $display("FAIL wrap_rdaddr0 got=%0h exp=0", mem_rdAddr); end
    tick; idle;
    tick;
    @(negedge clk);
    n_cmp++; if (wb_data !== 16'hA5A5) begin n_fail++; $display("FAIL wrap_ld0_data got=%0h exp=a5a5", wb_data); end
  endtask

  task test_reset_in_load_wait;
    tick; drive(1, 0, 16'h0005, 16'h0000, 3'd6, 1'b1);
    tick; idle;
    @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rstlw_in_wait got=%0h exp=0", ex_ready); end
    rst_n = 0;
    drive(0, 1, 16'h0009, 16'h5555, 3'd1, 1'b0);
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstlw_ready got=%0h exp=1", ex_ready); end
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rstlw_write got=%0h exp=0", mem_write); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstlw_wb0 got=%0h exp=0", wb_valid); end
    tick; idle;
    @(negedge clk);
    rst_n = 1;
    tick;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstlw_wb1 got=%0h exp=0", wb_valid); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstlw_ready_after got=%0h exp=1", ex_ready); end
    tick;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstlw_wb2 got=%0h exp=0", wb_valid); end
  endtask

  task test_err;
    tick; drive(1, 1, 16'h0007, 16'h0777, 3'd1, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL err_write got=%0h exp=1", mem_write); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL err_read got=%0h exp=0", mem_read); end
    n_cmp++; if (mem_wrAddr !== 4'h7) begin n_fail++; $display("FAIL err_wraddr got=%0h exp=7", mem_wrAddr); end
    n_cmp++; if (mem_rdAddr !== 4'h0) begin n_fail++; $display("FAIL err_rdaddr got=%0h exp=0", mem_rdAddr); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before got=%0h exp=0", err); end
    tick; idle;
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%0h exp=1", err); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL err_no_wait got=%0h exp=1", ex_ready); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL err_wb_rw got=%0h exp=0", wb_reg_write); end
    tick; drive(1, 0, 16'h0007, 16'h0000, 3'd1, 1'b1);
    tick; idle;
    tick;
    @(negedge clk);
    n_cmp++; if (wb_data !== 16'h0777) begin n_fail++; $display("FAIL err_stored got=%0h exp=777", wb_data); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%0h exp=1", err); end
    rst_n = 0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%0h exp=0", err); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task test_random;
    logic        v, ld, st, rw, acc, e_st, e_ld;
    logic [15:0] alu, sd;
    logic [2:0]  rd;
    logic [3:0]  a;
    int          k;
    logic [15:0] ref_mem [16];
    logic        m_stall, m_err, exp_v, exp_full, exp_rw;
    logic [2:0]  m_ld_rd, exp_rd;
    logic [3:0]  m_ld_addr;
    logic        m_ld_rw;
    logic [15:0] exp_data;
    rst_n = 0; idle;
    @(negedge clk);
    rst_n = 1;
    m_stall = 0; m_err = 0; exp_v = 0; exp_full = 0; exp_rw = 0; exp_rd = 0; exp_data = 0;
    m_ld_rd = 0; m_ld_addr = 0; m_ld_rw = 0;
    for (int c = 0; c < 400; c++) begin
      tick;
      v = ($urandom_range(0, 9) < 8); k = $urandom_range(0, 9);
      alu = 16'($urandom); sd = 16'($urandom); rd = 3'($urandom_range(0, 7)); rw = 1'($urandom_range(0, 1));
      ld = (k >= 3 && k <= 6); st = (k <= 2 || k == 6);
      if (c < 16) begin v = 1; ld = 0; st = 1; alu = 16'(c); end
      ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_alu_result = alu; ex_addr = alu[3:0];
      ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
      a = alu[3:0];
      acc = v && !m_stall; e_st = acc && st; e_ld = acc && ld && !st;
      @(negedge clk);
      n_cmp++; if (ex_ready !== !m_stall) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, ex_ready, !m_stall); end
      n_cmp++; if (mem_write !== e_st) begin n_fail++; $display("FAIL rnd_write c=%0d got=%0h exp=%0h", c, mem_write, e_st); end
      n_cmp++; if (mem_wrAddr !== (e_st ? a : 4'h0)) begin n_fail++; $display("FAIL rnd_wraddr c=%0d got=%0h exp=%0h", c, mem_wrAddr, e_st ? a : 4'h0); end
      n_cmp++; if (mem_data_in !== (e_st ? sd : 16'h0)) begin n_fail++; $display("FAIL rnd_data_in c=%0d got=%0h exp=%0h", c, mem_data_in, e_st ? sd : 16'h0); end
      n_cmp++; if (mem_read !== e_ld) begin n_fail++; $display("FAIL rnd_read c=%0d got=%0h exp=%0h", c, mem_read, e_ld); end
      n_cmp++; if (mem_rdAddr !== (e_ld ? a : 4'h0)) begin n_fail++; $display("FAIL rnd_rdaddr c=%0d got=%0h exp=%0h", c, mem_rdAddr, e_ld ? a : 4'h0); end
      n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%0h exp=%0h", c, err, m_err); end
      n_cmp++; if (wb_valid !== exp_v) begin n_fail++; $display("FAIL rnd_wb_valid c=%0d got=%0h exp=%0h", c, wb_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (wb_reg_write !== exp_rw) begin n_fail++; $display("FAIL rnd_wb_rw c=%0d got=%0h exp=%0h", c, wb_reg_write, exp_rw); end
      end
      if (exp_v && exp_full) begin
        n_cmp++; if (wb_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_wb_rd c=%0d got=%0h exp=%0h", c, wb_rd, exp_rd); end
        n_cmp++; if (wb_data !== exp_data) begin n_fail++; $display("FAIL rnd_wb_data c=%0d got=%0h exp=%0h", c, wb_data, exp_data); end
      end
      exp_v = 0; exp_full = 0;
      if (m_stall) begin
        exp_v = 1; exp_full = 1; exp_rd = m_ld_rd; exp_data = ref_mem[m_ld_addr]; exp_rw = m_ld_rw; m_stall = 0;
      end else if (e_st) begin
        ref_mem[a] = sd; exp_v = 1; exp_rw = 0;
        if (ld) m_err = 1;
      end else if (e_ld) begin
        m_stall = 1; m_ld_rd = rd; m_ld_addr = a; m_ld_rw = rw;
      end else if (acc) begin
        exp_v = 1; exp_full = 1; exp_rd = rd; exp_data = alu; exp_rw = rw;
      end
    end
    tick; idle;
  endtask

  initial begin
    idle;
    test_reset;
    test_store;
    test_store_load;
    test_back_to_back;
    test_addr_wrap;
    test_reset_in_load_wait;
    test_err;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
